// File: rtl/decoder_pkg.sv
// Shared FSM encoding and default select width for the decoder/sequencer block.
package decoder_pkg;

  localparam int DEFAULT_N = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    SEQ    = 2'd2
  } state_t;

endpackage

// File: rtl/onehot_dec.sv
// Combinational N-to-2**N one-hot decoder.
module onehot_dec
  import decoder_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0]      A,
  output logic [(2**N)-1:0] Y
);

  localparam int W = 2 ** N;

  assign Y = W'(1) << A;

endmodule

// File: rtl/decoder_seq_nx2n.sv
// Registered N-to-2**N decoder with a wrapping phase-sequencer mode.
// Define DECODER_SEQ_ERR_EN to add the sticky out-of-range select flag on output err.
module decoder_seq_nx2n
  import decoder_pkg::*;
#(
  parameter int          N    = DEFAULT_N,
  parameter int unsigned LAST = (2 ** N) - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              E,
  input  logic              mode,
  input  logic [N-1:0]      A,
  input  logic              load,
  input  logic              step,
  output logic [(2**N)-1:0] Y,
  output logic              wrap,
`ifdef DECODER_SEQ_ERR_EN
  output logic              err,
`endif
  output logic [N-1:0]      phase
);

  localparam int W = 2 ** N;

  state_t         r_state;
  state_t         w_nextState;
  logic [N-1:0]   r_phase;
  logic [N-1:0]   w_phaseNext;
  logic [N-1:0]   w_decSel;
  logic [W-1:0]   r_y;
  logic [W-1:0]   w_yDec;
  logic [W-1:0]   w_yNext;
  logic           r_wrap;
  logic           w_wrapNext;
  logic           w_loadA;
  logic           w_aOutOfRange;
  logic           w_phaseAtLast;

  // Compared at 32 bits so an A above LAST (or a phase loaded above it) is seen as out of range.
  assign w_aOutOfRange = 32'(A) > LAST;
  assign w_phaseAtLast = 32'(r_phase) >= LAST;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Entering SEQ from any other state always loads A, regardless of load/step.
  always_comb begin
    w_nextState = IDLE;
    w_phaseNext = r_phase;
    w_wrapNext  = 1'b0;
    w_loadA     = 1'b0;
    if (E) begin
      if (!mode) begin
        w_nextState = DECODE;
      end else begin
        w_nextState = SEQ;
        if ((r_state != SEQ) || load) begin
          w_phaseNext = A;
          w_loadA     = 1'b1;
        end else if (step) begin
          if (w_phaseAtLast) begin
            w_phaseNext = '0;
            w_wrapNext  = 1'b1;
          end else begin
            w_phaseNext = r_phase + N'(1);
          end
        end
      end
    end
  end

  assign w_decSel = (w_nextState == DECODE) ? A : w_phaseNext;

  onehot_dec #(
    .N(N)
  ) u_onehotDec (
    .A(w_decSel),
    .Y(w_yDec)
  );

  assign w_yNext = E ? w_yDec : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= '0;
      r_y     <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_phase <= w_phaseNext;
      r_y     <= w_yNext;
      r_wrap  <= w_wrapNext;
    end
  end

  assign Y     = r_y;
  assign wrap  = r_wrap;
  assign phase = r_phase;

`ifdef DECODER_SEQ_ERR_EN
  logic r_err;
  logic w_errSet;

  // Sticky: only rst clears it.
  assign w_errSet = E && (!mode || w_loadA) && w_aOutOfRange;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_errSet) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_decoder_seq_nx2n.sv
// Scoreboard bench for decoder_seq_nx2n: two instances (LAST=7 and LAST=4) share stimulus.
// Honours DECODER_SEQ_ERR_EN by also checking the err output.
module tb_decoder_seq_nx2n;

  typedef struct {
    logic [7:0] y;
    logic       wrap;
    logic [2:0] phase;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       E;
  logic       mode;
  logic [2:0] A;
  logic       load;
  logic       step;
  logic [7:0] y0, y1;
  logic       wrap0, wrap1;
  logic [2:0] phase0, phase1;
`ifdef DECODER_SEQ_ERR_EN
  logic       err0, err1;
`endif

  int checks   = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];

  int mPhase[2];
  bit mInSeq[2];
  bit mErr[2];

  decoder_seq_nx2n #(.N(3), .LAST(7)) u_dut0 (
    .clk(clk), .rst(rst), .E(E), .mode(mode), .A(A), .load(load), .step(step),
    .Y(y0), .wrap(wrap0),
`ifdef DECODER_SEQ_ERR_EN
    .err(err0),
`endif
    .phase(phase0)
  );

  decoder_seq_nx2n #(.N(3), .LAST(4)) u_dut1 (
    .clk(clk), .rst(rst), .E(E), .mode(mode), .A(A), .load(load), .step(step),
    .Y(y1), .wrap(wrap1),
`ifdef DECODER_SEQ_ERR_EN
    .err(err1),
`endif
    .phase(phase1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: tracks only "are we sequencing", the phase and the sticky error.
  function automatic exp_t modelStep(int k, bit e, bit m, int a, bit ld, bit st);
    exp_t x;
    int   last;
    last   = (k == 0) ? 7 : 4;
    x.y    = '0;
    x.wrap = 1'b0;
    if (!e) begin
      mInSeq[k] = 1'b0;
    end else if (!m) begin
      mInSeq[k] = 1'b0;
      x.y = 8'(1 << a);
      if (a > last) mErr[k] = 1'b1;
    end else begin
      if (!mInSeq[k] || ld) begin
        mPhase[k] = a;
        if (a > last) mErr[k] = 1'b1;
      end else if (st) begin
        if (mPhase[k] >= last) begin
          mPhase[k] = 0;
          x.wrap = 1'b1;
        end else begin
          mPhase[k] = mPhase[k] + 1;
        end
      end
      mInSeq[k] = 1'b1;
      x.y = 8'(1 << mPhase[k]);
    end
    x.phase = 3'(mPhase[k]);
    x.err   = mErr[k];
    return x;
  endfunction

  task automatic applyStimulus(input bit e, input bit m, input int a, input bit ld, input bit st);
    E    = e;
    mode = m;
    A    = 3'(a);
    load = ld;
    step = st;
    q0.push_back(modelStep(0, e, m, a, ld, st));
    q1.push_back(modelStep(1, e, m, a, ld, st));
    @(posedge clk);
    #2;
  endtask

  // Asynchronous reset between edges; outputs must clear without any clock edge.
  task automatic pulseReset();
    rst = 1'b1;
    E   = 1'b0;
    #1;
    checkOutput("rst_y_last7", int'(y0), 0);
    checkOutput("rst_phase_last7", int'(phase0), 0);
    checkOutput("rst_wrap_last7", int'(wrap0), 0);
    checkOutput("rst_y_last4", int'(y1), 0);
    checkOutput("rst_phase_last4", int'(phase1), 0);
    checkOutput("rst_wrap_last4", int'(wrap1), 0);
`ifdef DECODER_SEQ_ERR_EN
    checkOutput("rst_err_last7", int'(err0), 0);
    checkOutput("rst_err_last4", int'(err1), 0);
`endif
    #1;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mPhase[k] = 0;
      mInSeq[k] = 1'b0;
      mErr[k]   = 1'b0;
    end
  endtask

  // Monitor: one expected entry per clock edge, compared 1 time unit after the edge.
  initial begin
    exp_t x0;
    exp_t x1;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0 && q1.size() > 0) begin
        x0 = q0.pop_front();
        x1 = q1.pop_front();
        checkOutput("y_last7", int'(y0), int'(x0.y));
        checkOutput("wrap_last7", int'(wrap0), int'(x0.wrap));
        checkOutput("phase_last7", int'(phase0), int'(x0.phase));
        checkOutput("y_last4", int'(y1), int'(x1.y));
        checkOutput("wrap_last4", int'(wrap1), int'(x1.wrap));
        checkOutput("phase_last4", int'(phase1), int'(x1.phase));
`ifdef DECODER_SEQ_ERR_EN
        checkOutput("err_last7", int'(err0), int'(x0.err));
        checkOutput("err_last4", int'(err1), int'(x1.err));
`endif
      end
    end
  end

  initial begin
    int decA[5];
    decA = '{0, 1, 2, 3, 7};
    rst  = 1'b0;
    E    = 1'b0;
    mode = 1'b0;
    A    = '0;
    load = 1'b0;
    step = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mPhase[k] = 0;
      mInSeq[k] = 1'b0;
      mErr[k]   = 1'b0;
    end
    #1;
    rst = 1'b1;
    #2;
    checkOutput("por_y_last7", int'(y0), 0);
    checkOutput("por_phase_last7", int'(phase0), 0);
    checkOutput("por_wrap_last7", int'(wrap0), 0);
    checkOutput("por_y_last4", int'(y1), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Disabled, then plain decode of several selects.
    applyStimulus(0, 0, 0, 0, 0);
    foreach (decA[i]) applyStimulus(1, 0, decA[i], 0, 0);

    // Sequencer entry at 5 and three steps through the wrap.
    applyStimulus(1, 1, 5, 0, 0);
    repeat (3) applyStimulus(1, 1, 0, 0, 1);

    // load beats step.
    applyStimulus(1, 1, 3, 1, 0);
    applyStimulus(1, 1, 6, 1, 1);

    // Mid-sequence async reset, then re-entry loads A.
    applyStimulus(1, 1, 5, 1, 0);
    pulseReset();
    applyStimulus(1, 1, 4, 0, 0);

    // Load above LAST on the LAST=4 instance, then step wraps it.
    applyStimulus(1, 1, 6, 1, 0);
    applyStimulus(1, 1, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 1);

    // One disabled cycle inside SEQ, then re-entry at 2; load/step ignored in DECODE.
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(1, 1, 2, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 0, 4, 1, 1);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                    int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 4) < 3));
      if ($urandom_range(0, 49) == 0) pulseReset();
    end

    @(posedge clk);
    #2;
    checkOutput("scoreboard_drain", q0.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
